// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Packs an instruction kind, register fields and a 64-bit signed offset into a
// 32-bit LEGv8 word (B, CBZ, LDUR, STUR). It is the inverse of the decode-side
// immediate sign-extension path. Encoded words go through a 2-entry output
// FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   in_valid   in   1  request present
//   in_ready   out  1  encoder can accept (buffer not FULL)
//   in_kind    in   2  0=B, 1=CBZ, 2=LDUR, 3=STUR
//   in_rt      in   5  Rt field (ignored for B)
//   in_rn      in   5  Rn field (LDUR/STUR only)
//   in_imm     in  64  signed offset (words for B/CBZ, bytes for LDUR/STUR)
//   out_valid  out  1  encoded word available
//   out_ready  in   1  consumer accepts
//   out_instr  out 32  encoded instruction (head entry)
//   out_err    out  1  head word's offset did not fit its field
//   err_count  out 16  saturating count of out-of-range requests accepted
//
// Configuration macro:
//   IMM_ENCODER_RANGE_CHECK_EN  when defined, offsets are range-checked and
//   each buffer entry carries an error flag (33 bits). When undefined, offsets
//   are silently truncated, out_err and err_count are tied to 0, and entries
//   are 32 bits.
// -----------------------------------------------------------------------------
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rn,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_B    = 2'd0,
    KIND_CBZ  = 2'd1,
    KIND_LDUR = 2'd2,
    KIND_STUR = 2'd3
  } kind_t;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam int ENTRY_W = 33;
`else
  localparam int ENTRY_W = 32;
`endif

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   slot0_q, slot1_q;   // slot0 is always the head
  logic [ENTRY_W-1:0]   new_entry;
  logic [31:0]          enc_word;
  logic                 accept, drain;
  logic                 load_head, load_tail, head_from_tail;

  // ---------------------------------------------------------------------------
  // Field packing; out-of-range offsets are truncated to the field width.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    enc_word = '0;
    case (kind_t'(in_kind))
      KIND_B:    enc_word = {6'b000101, in_imm[25:0]};
      KIND_CBZ:  enc_word = {8'b10110100, in_imm[18:0], in_rt};
      KIND_LDUR: enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt};
      KIND_STUR: enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt};
      default:   enc_word = '0;
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  // The offset fits when every bit from the field's sign bit upward is equal,
  // i.e. sign-extending the packed field reproduces in_imm.
  logic        enc_err;
  logic [15:0] err_cnt_q;

  always_comb begin
    enc_err = 1'b0;
    case (kind_t'(in_kind))
      KIND_B:   enc_err = !((&in_imm[63:25]) || !(|in_imm[63:25]));
      KIND_CBZ: enc_err = !((&in_imm[63:18]) || !(|in_imm[63:18]));
      default:  enc_err = !((&in_imm[63:8])  || !(|in_imm[63:8]));
    endcase
  end

  assign new_entry = {enc_err, enc_word};
  assign out_err   = slot0_q[32];
  assign err_count = err_cnt_q;

  // Counted on the accept edge; holds at 16'hFFFF once saturated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (accept && enc_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^in_imm[63:26];
  assign new_entry     = enc_word;
  assign out_err       = 1'b0;
  assign err_count     = '0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode. in_ready depends on registered state only, so there is
  // no combinational path from out_ready to in_ready.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_instr = slot0_q[31:0];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Buffer FSM: next state and slot load controls.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          // Head leaves while the new word takes its place: still one entry.
          load_head = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_tail = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d        = ONE;
          load_head      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      // NOTE: the storage slots are reset as well, because out_instr and
      // out_err are read straight from the head slot and must be 0 in reset.
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_head) slot0_q <= head_from_tail ? slot1_q : new_entry;
      if (load_tail) slot1_q <= new_entry;
    end
  end

endmodule
